// File: rtl/cmd_frame_master.sv
// cmd_frame_master: host-side initiator for the UART command protocol.
// Turns one parallel command into a framed byte sequence on the UART_TX side
// (AA write, BB read, CC ALU with operands, DD ALU without operands) and
// assembles the controller's reply bytes from UART_RX into one response word.
// Optional build macro CMD_FRAME_TIMEOUT_EN adds a response watchdog that
// completes a stalled command with RSP_ERR=1 after TIMEOUT_CYCLES idle cycles.
module cmd_frame_master #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int OP_WIDTH       = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    CMD_VLD,
   output logic                    CMD_RDY,
   input  logic [1:0]              CMD_TYPE,
   input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
   input  logic [DATA_WIDTH-1:0]   CMD_DATA,
   input  logic [DATA_WIDTH-1:0]   CMD_OP_A,
   input  logic [DATA_WIDTH-1:0]   CMD_OP_B,
   input  logic [OP_WIDTH-1:0]     CMD_FUN,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   input  logic                    TX_BUSY,
   input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
   input  logic                    RX_D_VLD,
   output logic [2*DATA_WIDTH-1:0] RSP_DATA,
   output logic                    RSP_VLD,
   output logic                    RSP_ERR
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEND    = 3'd1,
      ST_WAIT_LO = 3'd2,
      ST_WAIT_HI = 3'd3,
      ST_RESP    = 3'd4
   } state_t;

   localparam logic [1:0] CMD_WR      = 2'd0;
   localparam logic [1:0] CMD_RD      = 2'd1;
   localparam logic [1:0] CMD_ALU_OP  = 2'd2;
   localparam logic [1:0] CMD_ALU_NOP = 2'd3;

   state_t                  state_q, state_d;
   logic [1:0]              idx_q, idx_d;
   logic [1:0]              type_q, type_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [DATA_WIDTH-1:0]   op_a_q, op_a_d;
   logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;
   logic [OP_WIDTH-1:0]     fun_q, fun_d;
   logic [DATA_WIDTH-1:0]   lo_q, lo_d;
   logic                    cmd_rdy_q, cmd_rdy_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic                    tx_vld_q, tx_vld_d;
   logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                    rsp_vld_q, rsp_vld_d;

`ifdef CMD_FRAME_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    rsp_err_q, rsp_err_d;
`endif

   // Header byte identifying the frame type.
   function automatic logic [DATA_WIDTH-1:0] header_byte(input logic [1:0] typ);
      case (typ)
         CMD_WR:      header_byte = DATA_WIDTH'(8'hAA);
         CMD_RD:      header_byte = DATA_WIDTH'(8'hBB);
         CMD_ALU_OP:  header_byte = DATA_WIDTH'(8'hCC);
         CMD_ALU_NOP: header_byte = DATA_WIDTH'(8'hDD);
         default:     header_byte = {DATA_WIDTH{1'b0}};
      endcase
   endfunction

   // Index of the final byte of each frame type.
   function automatic logic [1:0] last_idx(input logic [1:0] typ);
      case (typ)
         CMD_WR:      last_idx = 2'd2;
         CMD_RD:      last_idx = 2'd1;
         CMD_ALU_OP:  last_idx = 2'd3;
         CMD_ALU_NOP: last_idx = 2'd1;
         default:     last_idx = 2'd0;
      endcase
   endfunction

   // Frame byte at position idx; narrow fields are zero-extended on the wire.
   function automatic logic [DATA_WIDTH-1:0] frame_byte(
      input logic [1:0]            typ,
      input logic [1:0]            idx,
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [DATA_WIDTH-1:0] data,
      input logic [DATA_WIDTH-1:0] op_a,
      input logic [DATA_WIDTH-1:0] op_b,
      input logic [OP_WIDTH-1:0]   fun
   );
      frame_byte = {DATA_WIDTH{1'b0}};
      if (idx == 2'd0) begin
         frame_byte = header_byte(typ);
      end else begin
         case (typ)
            CMD_WR:      frame_byte = (idx == 2'd1) ? DATA_WIDTH'(addr) : data;
            CMD_RD:      frame_byte = DATA_WIDTH'(addr);
            CMD_ALU_OP:  frame_byte = (idx == 2'd1) ? op_a :
                                      (idx == 2'd2) ? op_b : DATA_WIDTH'(fun);
            CMD_ALU_NOP: frame_byte = DATA_WIDTH'(fun);
            default:     frame_byte = {DATA_WIDTH{1'b0}};
         endcase
      end
   endfunction

   // Next-state and next-output computation for the command sequencer.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      type_d     = type_q;
      addr_d     = addr_q;
      data_d     = data_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      fun_d      = fun_q;
      lo_d       = lo_q;
      cmd_rdy_d  = cmd_rdy_q;
      tx_data_d  = tx_data_q;
      tx_vld_d   = tx_vld_q;
      rsp_data_d = rsp_data_q;
      rsp_vld_d  = 1'b0;
`ifdef CMD_FRAME_TIMEOUT_EN
      cnt_d      = cnt_q;
      rsp_err_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            cmd_rdy_d = 1'b1;
            if (CMD_VLD && cmd_rdy_q) begin
               type_d    = CMD_TYPE;
               addr_d    = CMD_ADDR;
               data_d    = CMD_DATA;
               op_a_d    = CMD_OP_A;
               op_b_d    = CMD_OP_B;
               fun_d     = CMD_FUN;
               cmd_rdy_d = 1'b0;
               idx_d     = 2'd0;
               tx_data_d = header_byte(CMD_TYPE);
               tx_vld_d  = 1'b1;
               state_d   = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (tx_vld_q && !TX_BUSY) begin
               if (idx_q != last_idx(type_q)) begin
                  idx_d     = idx_q + 2'd1;
                  tx_data_d = frame_byte(type_q, idx_q + 2'd1, addr_q, data_q,
                                         op_a_q, op_b_q, fun_q);
               end else begin
                  tx_vld_d  = 1'b0;
                  tx_data_d = {DATA_WIDTH{1'b0}};
                  if (type_q == CMD_WR) begin
                     rsp_data_d = {(2*DATA_WIDTH){1'b0}};
                     rsp_vld_d  = 1'b1;
                     state_d    = ST_RESP;
                  end else begin
                     state_d = ST_WAIT_LO;
`ifdef CMD_FRAME_TIMEOUT_EN
                     cnt_d   = {CNT_W{1'b0}};
`endif
                  end
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_WAIT_LO: begin
            if (RX_D_VLD) begin
               if (type_q == CMD_RD) begin
                  rsp_data_d = {{DATA_WIDTH{1'b0}}, RX_P_DATA};
                  rsp_vld_d  = 1'b1;
                  state_d    = ST_RESP;
               end else begin
                  lo_d    = RX_P_DATA;
                  state_d = ST_WAIT_HI;
               end
`ifdef CMD_FRAME_TIMEOUT_EN
               cnt_d = {CNT_W{1'b0}};
            end else if (cnt_q == CNT_LAST) begin
               rsp_data_d = {(2*DATA_WIDTH){1'b0}};
               rsp_err_d  = 1'b1;
               rsp_vld_d  = 1'b1;
               state_d    = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1'b1);
            end
`else
            end else begin
               state_d = ST_WAIT_LO;
            end
`endif
         end
         ST_WAIT_HI: begin
            if (RX_D_VLD) begin
               rsp_data_d = {RX_P_DATA, lo_q};
               rsp_vld_d  = 1'b1;
               state_d    = ST_RESP;
`ifdef CMD_FRAME_TIMEOUT_EN
               cnt_d = {CNT_W{1'b0}};
            end else if (cnt_q == CNT_LAST) begin
               rsp_data_d = {{DATA_WIDTH{1'b0}}, lo_q};
               rsp_err_d  = 1'b1;
               rsp_vld_d  = 1'b1;
               state_d    = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1'b1);
            end
`else
            end else begin
               state_d = ST_WAIT_HI;
            end
`endif
         end
         ST_RESP: begin
            cmd_rdy_d = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            tx_vld_d  = 1'b0;
            cmd_rdy_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= ST_IDLE;
         idx_q      <= 2'd0;
         type_q     <= 2'd0;
         addr_q     <= {ADDR_WIDTH{1'b0}};
         data_q     <= {DATA_WIDTH{1'b0}};
         op_a_q     <= {DATA_WIDTH{1'b0}};
         op_b_q     <= {DATA_WIDTH{1'b0}};
         fun_q      <= {OP_WIDTH{1'b0}};
         lo_q       <= {DATA_WIDTH{1'b0}};
         cmd_rdy_q  <= 1'b0;
         tx_data_q  <= {DATA_WIDTH{1'b0}};
         tx_vld_q   <= 1'b0;
         rsp_data_q <= {(2*DATA_WIDTH){1'b0}};
         rsp_vld_q  <= 1'b0;
`ifdef CMD_FRAME_TIMEOUT_EN
         cnt_q      <= {CNT_W{1'b0}};
         rsp_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         type_q     <= type_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         fun_q      <= fun_d;
         lo_q       <= lo_d;
         cmd_rdy_q  <= cmd_rdy_d;
         tx_data_q  <= tx_data_d;
         tx_vld_q   <= tx_vld_d;
         rsp_data_q <= rsp_data_d;
         rsp_vld_q  <= rsp_vld_d;
`ifdef CMD_FRAME_TIMEOUT_EN
         cnt_q      <= cnt_d;
         rsp_err_q  <= rsp_err_d;
`endif
      end
   end

   assign CMD_RDY   = cmd_rdy_q;
   assign TX_P_DATA = tx_data_q;
   assign TX_D_VLD  = tx_vld_q;
   assign RSP_DATA  = rsp_data_q;
   assign RSP_VLD   = rsp_vld_q;
`ifdef CMD_FRAME_TIMEOUT_EN
   assign RSP_ERR   = rsp_err_q;
`else
   assign RSP_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_frame_master.sv
// Directed bench for cmd_frame_master: expected TX bytes and response words
// are queued when a command is issued and popped as the DUT produces them.
module tb_cmd_frame_master;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int OW = 4;
   localparam int TO = 16;

   logic            clk;
   logic            rst;
   logic            cmd_vld;
   logic            cmd_rdy;
   logic [1:0]      cmd_type;
   logic [AW-1:0]   cmd_addr;
   logic [DW-1:0]   cmd_data;
   logic [DW-1:0]   cmd_op_a;
   logic [DW-1:0]   cmd_op_b;
   logic [OW-1:0]   cmd_fun;
   logic [DW-1:0]   tx_p_data;
   logic            tx_d_vld;
   logic            tx_busy;
   logic [DW-1:0]   rx_p_data;
   logic            rx_d_vld;
   logic [2*DW-1:0] rsp_data;
   logic            rsp_vld;
   logic            rsp_err;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int rsp_cnt     = 0;
   int rsp_cyc     = -1;

   logic [DW-1:0]   tx_q[$];
   logic [2*DW:0]   rsp_q[$];
   int              xfer_cycs[$];
   logic            hold_pending = 1'b0;
   logic [DW-1:0]   hold_data    = 8'h00;

   cmd_frame_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(OW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK(clk), .RST(rst),
      .CMD_VLD(cmd_vld), .CMD_RDY(cmd_rdy), .CMD_TYPE(cmd_type),
      .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data), .CMD_OP_A(cmd_op_a),
      .CMD_OP_B(cmd_op_b), .CMD_FUN(cmd_fun),
      .TX_P_DATA(tx_p_data), .TX_D_VLD(tx_d_vld), .TX_BUSY(tx_busy),
      .RX_P_DATA(rx_p_data), .RX_D_VLD(rx_d_vld),
      .RSP_DATA(rsp_data), .RSP_VLD(rsp_vld), .RSP_ERR(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Observe the current cycle (inputs already set for the coming edge), then advance one clock.
   task automatic cycle();
      logic [DW-1:0] eb;
      logic [2*DW:0] er;
      if (hold_pending) begin
         check("tx_hold_vld", {31'd0, tx_d_vld}, 32'd1);
         check("tx_hold_data", {24'd0, tx_p_data}, {24'd0, hold_data});
      end
      hold_pending = (tx_d_vld === 1'b1) && (tx_busy === 1'b1);
      hold_data    = tx_p_data;
      if (tx_d_vld === 1'b1 && tx_busy === 1'b0) begin
         check("tx_expected", {31'd0, tx_q.size() > 0}, 32'd1);
         if (tx_q.size() > 0) begin
            eb = tx_q.pop_front();
            check("tx_byte", {24'd0, tx_p_data}, {24'd0, eb});
         end
         xfer_cycs.push_back(cyc);
      end
      if (rsp_vld === 1'b1) begin
         check("rsp_expected", {31'd0, rsp_q.size() > 0}, 32'd1);
         if (rsp_q.size() > 0) begin
            er = rsp_q.pop_front();
            check("rsp_word", {15'd0, rsp_err, rsp_data}, {15'd0, er});
         end
         rsp_cyc = cyc;
         rsp_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic send_cmd(input logic [1:0] typ, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [OW-1:0] fun,
                           output int t1);
      case (typ)
         2'd0: begin tx_q.push_back(8'hAA); tx_q.push_back({4'h0, addr}); tx_q.push_back(data); end
         2'd1: begin tx_q.push_back(8'hBB); tx_q.push_back({4'h0, addr}); end
         2'd2: begin tx_q.push_back(8'hCC); tx_q.push_back(a); tx_q.push_back(b); tx_q.push_back({4'h0, fun}); end
         default: begin tx_q.push_back(8'hDD); tx_q.push_back({4'h0, fun}); end
      endcase
      check("cmd_rdy_before", {31'd0, cmd_rdy}, 32'd1);
      cmd_vld  = 1'b1;
      cmd_type = typ;
      cmd_addr = addr;
      cmd_data = data;
      cmd_op_a = a;
      cmd_op_b = b;
      cmd_fun  = fun;
      xfer_cycs.delete();
      cycle();
      // scramble fields to show they were captured at the accept edge
      cmd_vld  = 1'b0;
      cmd_addr = ~addr;
      cmd_data = ~data;
      cmd_op_a = ~a;
      cmd_op_b = ~b;
      cmd_fun  = ~fun;
      cmd_type = ~typ;
      t1 = cyc;
      check("hdr_vld", {31'd0, tx_d_vld}, 32'd1);
      check("cmd_rdy_drop", {31'd0, cmd_rdy}, 32'd0);
   endtask

   task automatic wait_rsp(input int budget);
      int n0;
      n0 = rsp_cnt;
      for (int i = 0; i < budget && rsp_cnt == n0; i++) cycle();
      check("rsp_seen", {31'd0, rsp_cnt != n0}, 32'd1);
      if (rsp_cnt != n0) check("cmd_rdy_after_resp", {31'd0, cmd_rdy}, 32'd1);
   endtask

   task automatic check_xfers(input string tag, input int t1, input int n);
      check(tag, xfer_cycs.size(), n);
      for (int i = 0; i < xfer_cycs.size(); i++) check(tag, xfer_cycs[i], t1 + i);
   endtask

   task automatic send_rx(input logic [DW-1:0] b, output int c);
      rx_p_data = b;
      rx_d_vld  = 1'b1;
      c = cyc;
      cycle();
      rx_d_vld  = 1'b0;
      rx_p_data = 8'h00;
   endtask

   task automatic check_all_zero();
      check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
      check("rst_tx_vld", {31'd0, tx_d_vld}, 32'd0);
      check("rst_tx_data", {24'd0, tx_p_data}, 32'd0);
      check("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
   endtask

   initial begin
      int t1;
      int rc;
      int n0;
      rst = 1'b0; cmd_vld = 1'b0; cmd_type = 2'd0; cmd_addr = 4'h0;
      cmd_data = 8'h00; cmd_op_a = 8'h00; cmd_op_b = 8'h00; cmd_fun = 4'h0;
      tx_busy = 1'b0; rx_p_data = 8'h00; rx_d_vld = 1'b0;
      run(3);
      check_all_zero();
      rst = 1'b1;
      cycle();
      check("rdy_after_release", {31'd0, cmd_rdy}, 32'd1);

      // WR addr=3 data=5A
      rsp_q.push_back({1'b0, 16'h0000});
      send_cmd(2'd0, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0, t1);
      wait_rsp(20);
      check_xfers("wr_xfer_cyc", t1, 3);
      check("wr_rsp_cyc", rsp_cyc, t1 + 3);

      // RD addr=7, reply 3C
      rsp_q.push_back({1'b0, 16'h003C});
      send_cmd(2'd1, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0, t1);
      run(5);
      check_xfers("rd_xfer_cyc", t1, 2);
      check("rd_tx_idle", {31'd0, tx_d_vld}, 32'd0);
      send_rx(8'h3C, rc);
      wait_rsp(20);
      check("rd_rsp_cyc", rsp_cyc, rc + 1);

      // ALU_OP A=12 B=34 fun=1, reply lo=46 hi=00
      rsp_q.push_back({1'b0, 16'h0046});
      send_cmd(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1, t1);
      run(5);
      check_xfers("alu_xfer_cyc", t1, 4);
      send_rx(8'h46, rc);
      run(2);
      send_rx(8'h00, rc);
      wait_rsp(20);
      check("alu_rsp_cyc", rsp_cyc, rc + 1);

      // ALU_NOP fun=2 with header stalled by TX_BUSY for 5 cycles, stray RX during SEND
      rsp_q.push_back({1'b0, 16'h9A78});
      tx_busy = 1'b1;
      send_cmd(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, t1);
      for (int i = 0; i < 5; i++) begin
         check("nop_hold_hdr", {24'd0, tx_p_data}, 32'h0000_00DD);
         if (i == 2) begin
            rx_p_data = 8'hFF;
            rx_d_vld  = 1'b1;
         end
         cycle();
         rx_d_vld = 1'b0;
      end
      tx_busy = 1'b0;
      run(3);
      check_xfers("nop_xfer_cyc", t1 + 5, 2);
      send_rx(8'h78, rc);
      send_rx(8'h9A, rc);
      wait_rsp(20);
      check("nop_rsp_cyc", rsp_cyc, rc + 1);

      // RD with no reply
`ifdef CMD_FRAME_TIMEOUT_EN
      rsp_q.push_back({1'b1, 16'h0000});
      send_cmd(2'd1, 4'h1, 8'h00, 8'h00, 8'h00, 4'h0, t1);
      wait_rsp(60);
      check("to_rsp_cyc", rsp_cyc, t1 + 2 + TO);
`else
      send_cmd(2'd1, 4'h1, 8'h00, 8'h00, 8'h00, 4'h0, t1);
      n0 = rsp_cnt;
      run(40);
      check("no_to_rsp", rsp_cnt, n0);
      check("no_to_rdy", {31'd0, cmd_rdy}, 32'd0);
      rsp_q.push_back({1'b0, 16'h0055});
      send_rx(8'h55, rc);
      wait_rsp(20);
      check("late_rsp_cyc", rsp_cyc, rc + 1);
`endif

      // Reset after the second byte of an ALU_OP frame
      send_cmd(2'd2, 4'h0, 8'h00, 8'hA1, 8'hB2, 4'h3, t1);
      run(2);
      n0 = rsp_cnt;
      rst = 1'b0;
      cycle();
      tx_q.delete();
      for (int i = 0; i < 3; i++) begin
         check_all_zero();
         cycle();
      end
      rst = 1'b1;
      cycle();
      check("rdy_after_abort", {31'd0, cmd_rdy}, 32'd1);
      check("tx_idle_after_abort", {31'd0, tx_d_vld}, 32'd0);
      run(4);
      check("no_rsp_after_abort", rsp_cnt, n0);

      // Recovery: a write completes normally after the abort
      rsp_q.push_back({1'b0, 16'h0000});
      send_cmd(2'd0, 4'hF, 8'hC3, 8'h00, 8'h00, 4'h0, t1);
      wait_rsp(20);
      check_xfers("wr2_xfer_cyc", t1, 3);
      check("wr2_rsp_cyc", rsp_cyc, t1 + 3);

      check("tx_q_drained", tx_q.size(), 0);
      check("rsp_q_drained", rsp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cmd_frame_master.md
Name: cmd_frame_master

Overview:
- Host-side initiator for the UART command protocol consumed by the system controller.
- Converts a parallel command request into the byte frames below and pushes them into UART_TX.
  - 0xAA write
  - 0xBB read
  - 0xCC ALU with operands
  - 0xDD ALU without operands
- Collects response bytes from UART_RX and returns one assembled response word per command.
- Used as the bench/host-emulation end of the link, and as an on-chip sequencer in loopback builds.

Parameters:
DATA_WIDTH, 8, UART byte width
ADDR_WIDTH, 4, register-file address width; zero-extended to DATA_WIDTH on the wire
OP_WIDTH, 4, ALU function width; zero-extended to DATA_WIDTH on the wire
TIMEOUT_CYCLES, 4096, response wait limit in CLK cycles (used only with the optional feature)

Ports:
CLK  in  1  single clock
RST  in  1  synchronous, active-low reset
CMD_VLD  in  1  command request valid
CMD_RDY  out  1  block can accept a command
CMD_TYPE  in  2  0=WR, 1=RD, 2=ALU_OP, 3=ALU_NOP
CMD_ADDR  in  ADDR_WIDTH  RF address (WR/RD)
CMD_DATA  in  DATA_WIDTH  write data (WR)
CMD_OP_A  in  DATA_WIDTH  operand A (ALU_OP)
CMD_OP_B  in  DATA_WIDTH  operand B (ALU_OP)
CMD_FUN  in  OP_WIDTH  ALU function (ALU_OP/ALU_NOP)
TX_P_DATA  out  DATA_WIDTH  byte to UART_TX
TX_D_VLD  out  1  byte valid
TX_BUSY  in  1  UART_TX cannot take a byte this cycle
RX_P_DATA  in  DATA_WIDTH  byte from UART_RX
RX_D_VLD  in  1  single-cycle RX byte strobe
RSP_DATA  out  2*DATA_WIDTH  response word
RSP_VLD  out  1  one-cycle response/completion pulse
RSP_ERR  out  1  response timed out (valid with RSP_VLD)

Behaviour:
- Reset and registering:
  - Reset is sampled on the CLK edge only.
  - While RST=0, all outputs are 0 (CMD_RDY included) and the FSM is in IDLE.
  - All outputs are registered.
- Command acceptance:
  - CMD_RDY=1 only in IDLE, starting the first cycle after reset release.
  - A command is accepted on the edge where CMD_VLD&&CMD_RDY=1; all CMD_* fields are captured at that edge.
  - CMD_RDY drops the next cycle.
- Frame bytes, in order:
  - WR: AA, addr, data
  - RD: BB, addr
  - ALU_OP: CC, A, B, fun
  - ALU_NOP: DD, fun
- TX handshake:
  - A byte transfers on an edge with TX_D_VLD=1 and TX_BUSY=0.
  - While TX_BUSY=1, TX_P_DATA and TX_D_VLD hold stable.
  - The header byte is presented with TX_D_VLD=1 the cycle after acceptance.
  - Each following byte is presented the cycle after the previous transfer; TX_D_VLD stays high across back-to-back bytes.
  - After the last byte transfers, TX_D_VLD=0 the next cycle.
- FSM states: IDLE -> SEND (byte index 0..len-1) -> WAIT_LO -> WAIT_HI -> RESP -> IDLE.
  - WR: SEND -> RESP directly. RSP_DATA=0 and RSP_VLD pulses the cycle after the last byte transfers.
  - RD: SEND -> WAIT_LO.
    - On RX_D_VLD, capture RSP_DATA={0,RX_P_DATA}.
    - Go to RESP; RSP_VLD pulses the next cycle.
  - ALU_OP/ALU_NOP: SEND -> WAIT_LO -> WAIT_HI -> RESP.
    - The first RX byte is the low byte and the second is the high byte.
    - RSP_DATA={hi,lo}.
  - RESP lasts 1 cycle. CMD_RDY=1 again the cycle after RESP.
  - RSP_DATA holds its value until the next RESP.
- RX handling outside WAIT_*: RX_D_VLD in IDLE or SEND is ignored and the byte is dropped; there is no buffering.
- Reset mid-operation:
  - The frame is aborted; no further bytes are sent.
  - No RSP_VLD is generated.
  - The block returns to IDLE with all outputs 0.
- CMD_VLD while CMD_RDY=0 has no effect.

Optional Feature:
- Macro: CMD_FRAME_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_LO and on every RX byte, and increments every cycle spent in WAIT_*.
  - When the counter reaches TIMEOUT_CYCLES-1 with no RX byte, the FSM goes to RESP with RSP_ERR=1.
  - RSP_DATA holds the bytes received so far; missing bytes are 0.
  - If RX_D_VLD arrives on the expiry cycle, the byte wins and no error is raised.
  - RSP_ERR=0 for normal responses.
- Undefined: no counter logic; WAIT_* waits indefinitely; RSP_ERR is tied to 0.

Test Plan:
- WR addr=3 data=0x5A, TX_BUSY=0 -> TX bytes AA,03,5A on 3 consecutive cycles starting T+1; RSP_VLD=1 at T+4 with RSP_DATA=0x0000; CMD_RDY=1 at T+5.
- RD addr=7, then RX byte 0x3C -> TX bytes BB,07; RSP_DATA=0x003C with RSP_VLD the cycle after the RX strobe.
- ALU_OP A=0x12 B=0x34 fun=1, RX bytes 0x46 then 0x00 -> TX bytes CC,12,34,01; RSP_DATA=0x0046.
- ALU_NOP fun=2 with TX_BUSY high for 5 cycles on the header -> TX_P_DATA=0xDD held stable for 5 cycles; then DD,02 sent; stray RX byte 0xFF during SEND ignored.
- RD with no RX reply and CMD_FRAME_TIMEOUT_EN defined, TIMEOUT_CYCLES=16 -> RSP_VLD=1, RSP_ERR=1, RSP_DATA=0 after 16 cycles in WAIT_LO; without the macro, no RSP_VLD.
- Reset asserted after the second byte of an ALU_OP frame -> no further TX_D_VLD, no RSP_VLD, all outputs 0 during reset; CMD_RDY=1 the first cycle after release.
